// File: rtl/csr_commit_ctr.sv
// Per-core 64-bit mcycle/minstret counters fed by the commit stream, with 1-cycle CSR reads
// and machine-mode writes. Define CSR_CMT_PIPE_EN to register the commit beat before the add.
module csr_commit_ctr #(
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned CMT_LANES   = 6,
  localparam int unsigned CMT_W      = $clog2(CMT_LANES * NUM_THREADS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmt_valid,
  input  logic [CMT_W-1:0] cmt_size,
  input  logic             csr_rd_valid,
  input  logic [11:0]      csr_rd_addr,
  output logic [31:0]      csr_rd_data,
  output logic             csr_rd_ack,
  output logic             csr_rd_hit,
  input  logic             csr_wr_valid,
  input  logic [11:0]      csr_wr_addr,
  input  logic [31:0]      csr_wr_data
);

  logic [63:0]      mcycle_q, mcycle_d;
  logic [63:0]      minstret_q, minstret_d;
  logic             beat_valid;
  logic [CMT_W-1:0] beat_size;
  logic             wr_mcycle_lo, wr_mcycle_hi, wr_minstret_lo, wr_minstret_hi;
  logic             wr_minstret;
  logic [31:0]      rd_data_d;
  logic             rd_hit_d;

  assign wr_mcycle_lo   = csr_wr_valid && (csr_wr_addr == 12'hB00);
  assign wr_mcycle_hi   = csr_wr_valid && (csr_wr_addr == 12'hB80);
  assign wr_minstret_lo = csr_wr_valid && (csr_wr_addr == 12'hB02);
  assign wr_minstret_hi = csr_wr_valid && (csr_wr_addr == 12'hB82);
  assign wr_minstret    = wr_minstret_lo || wr_minstret_hi;

`ifdef CSR_CMT_PIPE_EN
  logic             stage_valid_q;
  logic [CMT_W-1:0] stage_size_q;

  assign beat_valid = stage_valid_q;
  assign beat_size  = stage_size_q;

  // A minstret write drops both the beat already staged and the one arriving now.
  always_ff @(posedge clk) begin
    if (reset || wr_minstret) begin
      stage_valid_q <= 1'b0;
      stage_size_q  <= '0;
    end else begin
      stage_valid_q <= cmt_valid;
      stage_size_q  <= cmt_size;
    end
  end
`else
  assign beat_valid = cmt_valid;
  assign beat_size  = cmt_size;
`endif

  // A written counter takes the new half and skips its increment that cycle.
  always_comb begin
    mcycle_d = mcycle_q + 64'd1;
    if (wr_mcycle_lo) begin
      mcycle_d = {mcycle_q[63:32], csr_wr_data};
    end else if (wr_mcycle_hi) begin
      mcycle_d = {csr_wr_data, mcycle_q[31:0]};
    end

    minstret_d = minstret_q;
    if (beat_valid) begin
      minstret_d = minstret_q + {{(64 - CMT_W){1'b0}}, beat_size};
    end
    if (wr_minstret_lo) begin
      minstret_d = {minstret_q[63:32], csr_wr_data};
    end else if (wr_minstret_hi) begin
      minstret_d = {csr_wr_data, minstret_q[31:0]};
    end
  end

  always_comb begin
    rd_hit_d  = 1'b1;
    rd_data_d = '0;
    case (csr_rd_addr)
      12'hB00, 12'hC00: rd_data_d = mcycle_q[31:0];
      12'hB80, 12'hC80: rd_data_d = mcycle_q[63:32];
      12'hB02, 12'hC02: rd_data_d = minstret_q[31:0];
      12'hB82, 12'hC82: rd_data_d = minstret_q[63:32];
      default:          rd_hit_d  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcycle_q    <= '0;
      minstret_q  <= '0;
      csr_rd_data <= '0;
      csr_rd_ack  <= 1'b0;
      csr_rd_hit  <= 1'b0;
    end else begin
      mcycle_q    <= mcycle_d;
      minstret_q  <= minstret_d;
      csr_rd_ack  <= csr_rd_valid;
      csr_rd_hit  <= csr_rd_valid && rd_hit_d;
      csr_rd_data <= csr_rd_valid ? rd_data_d : 32'd0;
    end
  end

endmodule
